// File: rtl/mux_somador.sv
// Registered select-then-add: one of B/C is chosen by sel_mux,
// added to A, and the WIDTH+1 bit sum is registered.
module mux_somador #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] entradaA,
  input  logic [WIDTH-1:0] entradaB,
  input  logic [WIDTH-1:0] entradaC,
  input  logic             sel_mux,
  output logic [WIDTH:0]   resultado_final
);

  logic [WIDTH-1:0] operand;
  logic [WIDTH:0]   sum_d;
  logic [WIDTH:0]   sum_q;

  always_comb begin
    operand = sel_mux ? entradaC : entradaB;
  end

  // Zero-extend both addends so the MSB carries out.
  always_comb begin
    sum_d = {1'b0, entradaA} + {1'b0, operand};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign resultado_final = sum_q;

endmodule

// File: tb/tb_mux_somador.sv
// Directed and random scoreboard bench for mux_somador.
// Results are queued at drive time and popped after each edge.
module tb_mux_somador;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] entradaA;
  logic [W-1:0] entradaB;
  logic [W-1:0] entradaC;
  logic         sel_mux;
  logic [W:0]   resultado_final;

  int errors = 0;
  int checks = 0;
  logic [W:0] exp_q[$];

  mux_somador #(.WIDTH(W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .entradaA        (entradaA),
    .entradaB        (entradaB),
    .entradaC        (entradaC),
    .sel_mux         (sel_mux),
    .resultado_final (resultado_final)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string tag,
                         input logic [W:0] exp);
    checks++;
    assert (resultado_final === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, resultado_final, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    logic [W:0] e;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $error("FAIL %s observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      compare(tag, e);
    end
  endtask

  task automatic step(input logic [W-1:0] a,
                      input logic [W-1:0] b,
                      input logic [W-1:0] c,
                      input logic s,
                      input logic r,
                      input logic [W:0] exp,
                      input string tag);
    @(negedge clk);
    entradaA = a;
    entradaB = b;
    entradaC = c;
    sel_mux  = s;
    rst_n    = r;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    pop_check(tag);
  endtask

  initial begin
    logic [W-1:0] ra, rb, rc;
    logic         rs;
    logic [W:0]   re;

    rst_n    = 1'b0;
    entradaA = 4'd15;
    entradaB = 4'd15;
    entradaC = 4'd0;
    sel_mux  = 1'b0;

    step(4'd15, 4'd15, 4'd0, 1'b0, 1'b0, 5'd0, "rst1");
    step(4'd15, 4'd15, 4'd0, 1'b0, 1'b0, 5'd0, "rst2");

    step(4'b0011, 4'b0101, 4'b0001, 1'b0, 1'b1,
         5'b01000, "selB");
    step(4'b0111, 4'b0000, 4'b0010, 1'b1, 1'b1,
         5'b01001, "selC");

    step(4'd15, 4'd15, 4'd0, 1'b0, 1'b1, 5'd30, "max");
    step(4'd15, 4'd15, 4'd0, 1'b1, 1'b1, 5'd15, "maxC");
    step(4'd0, 4'd0, 4'd0, 1'b0, 1'b1, 5'd0, "zero");
    step(4'd0, 4'd0, 4'd15, 1'b1, 1'b1, 5'd15, "zC15");

    for (int i = 0; i < 16; i++) begin
      step(4'd1, 4'd2, 4'(i), 1'b0, 1'b1, 5'd3, "isoC");
    end

    // Inputs wiggled between edges must not reach the output.
    #1;
    entradaA = 4'd15;
    entradaB = 4'd15;
    entradaC = 4'd9;
    sel_mux  = 1'b1;
    #1;
    compare("hold_in", 5'd3);
    rst_n = 1'b0;
    #1;
    compare("hold_rst", 5'd3);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compare("next_edge", 5'd24);

    step(4'b0111, 4'b0000, 4'b0010, 1'b1, 1'b1,
         5'd9, "pre_rst");
    step(4'b0111, 4'b0000, 4'b0010, 1'b1, 1'b0,
         5'd0, "mid_rst");
    step(4'd3, 4'd5, 4'd0, 1'b0, 1'b1, 5'd8, "post_rst");

    step(4'd9, 4'd6, 4'd1, 1'b0, 1'b1, 5'd15, "tgl0");
    step(4'd9, 4'd6, 4'd1, 1'b1, 1'b1, 5'd10, "tgl1");
    step(4'd9, 4'd6, 4'd1, 1'b0, 1'b1, 5'd15, "tgl2");

    for (int i = 0; i < 24; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 4'($urandom_range(0, 15));
      rs = 1'($urandom_range(0, 1));
      re = rs ? (5'(ra) + 5'(rc)) : (5'(ra) + 5'(rb));
      step(ra, rb, rc, rs, 1'b1, re, "rand");
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
